// File: rtl/linebuf_sched_if.sv
// Signal bundle between linebuf_sched and its pixel source, line buffer, convolver and status sink.
// master = environment side, slave = scheduler side.
interface linebuf_sched_if #(
  parameter int BIT_DEPTH = 8,
  parameter int COLS      = 28,
  parameter int IMG_ROWS  = 28
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

  logic                 frame_start;
  logic [1:0]           stride;
  logic                 pix_valid;
  logic [BIT_DEPTH-1:0] pix_data;
  logic                 pix_ready;
  logic                 lb_wr_en;
  logic [1:0]           lb_row_sel;
  logic [COL_W-1:0]     lb_col;
  logic [BIT_DEPTH-1:0] lb_data;
  logic                 conv_start;
  logic [1:0]           conv_stride;
  logic [1:0]           conv_top_slot;
  logic                 conv_done;
  logic                 busy;
  logic                 frame_done;
  logic [ROW_W-1:0]     out_row;
  logic                 err;

  modport master (
    output frame_start, stride, pix_valid, pix_data, conv_done,
    input  pix_ready, lb_wr_en, lb_row_sel, lb_col, lb_data,
           conv_start, conv_stride, conv_top_slot, busy, frame_done, out_row, err
  );

  modport slave (
    input  frame_start, stride, pix_valid, pix_data, conv_done,
    output pix_ready, lb_wr_en, lb_row_sel, lb_col, lb_data,
           conv_start, conv_stride, conv_top_slot, busy, frame_done, out_row, err
  );
endinterface

// File: rtl/linebuf_sched.sv
// Three-row line-buffer fill/convolve scheduler for a raster pixel stream, stride 1 or 2.
// Optional conv_done watchdog: define LINEBUF_SCHED_TIMEOUT_EN.
module linebuf_sched #(
  parameter int BIT_DEPTH      = 8,
  parameter int COLS           = 28,
  parameter int IMG_ROWS       = 28,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  linebuf_sched_if.slave bus
);
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
  localparam int LAST_S1 = IMG_ROWS - 3;
  localparam int LAST_S2 = (IMG_ROWS - 3) / 2;

  typedef enum logic [2:0] {IDLE, FILL, CONV, WAIT, REFILL} state_t;

  state_t           state, state_next;
  logic [COL_W-1:0] col;
  logic [1:0]       wr_slot, top_slot, rows;
  logic             stride2;
  logic [ROW_W-1:0] out_row;
  logic             frame_done;
  logic             pix_ready, accept, row_done, last_pass, timeout;
  logic             conv_start;
  logic [1:0]       conv_stride, conv_top_slot;

  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign pix_ready = (state == FILL) || (state == REFILL);
  assign accept    = bus.pix_valid && pix_ready;
  assign row_done  = accept && (col == COL_W'(COLS - 1));
  assign last_pass = out_row == (stride2 ? ROW_W'(LAST_S2) : ROW_W'(LAST_S1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    conv_start    = 1'b0;
    conv_stride   = 2'd0;
    conv_top_slot = 2'd0;
    unique case (state)
      IDLE:   if (bus.frame_start) state_next = FILL;
      FILL:   if (row_done && rows == 2'd2) state_next = CONV;
      REFILL: if (row_done && rows == {1'b0, stride2}) state_next = CONV;
      CONV: begin
        conv_start    = 1'b1;
        conv_stride   = stride2 ? 2'd2 : 2'd1;
        conv_top_slot = top_slot;
        state_next    = WAIT;
      end
      WAIT: begin
        if (bus.conv_done) state_next = last_pass ? IDLE : REFILL;
        else if (timeout)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      wr_slot    <= '0;
      top_slot   <= '0;
      rows       <= '0;
      stride2    <= 1'b0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE && bus.frame_start) begin
        stride2  <= (bus.stride == 2'd2);
        col      <= '0;
        wr_slot  <= '0;
        top_slot <= '0;
        rows     <= '0;
        out_row  <= '0;
      end
      if (accept) begin
        if (row_done) begin
          col     <= '0;
          wr_slot <= slot_inc(wr_slot);
          rows    <= (state_next == CONV) ? 2'd0 : rows + 2'd1;
          // Each freshly written row retires the oldest row of the window.
          if (state == REFILL) top_slot <= slot_inc(top_slot);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (state == WAIT && bus.conv_done) begin
        if (last_pass) begin
          out_row    <= '0;
          frame_done <= 1'b1;
        end else begin
          out_row <= out_row + ROW_W'(1);
        end
      end
    end
  end

`ifdef LINEBUF_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] wait_cnt;
  logic             err;

  // wait_cnt holds cycles elapsed since the conv_start cycle.
  assign timeout = (state == WAIT) && (wait_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout && !bus.conv_done;
      if (state == CONV)      wait_cnt <= TMR_W'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + TMR_W'(1);
    end
  end

  assign bus.err = err;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.pix_ready     = pix_ready;
  assign bus.lb_wr_en      = accept;
  assign bus.lb_row_sel    = wr_slot;
  assign bus.lb_col        = col;
  assign bus.lb_data       = pix_ready ? bus.pix_data : '0;
  assign bus.conv_start    = conv_start;
  assign bus.conv_stride   = conv_stride;
  assign bus.conv_top_slot = conv_top_slot;
  assign bus.busy          = (state != IDLE);
  assign bus.frame_done    = frame_done;
  assign bus.out_row       = out_row;
endmodule

// File: tb/tb_linebuf_sched.sv
// Scoreboard bench for linebuf_sched: frame stimulus pushes expected writes, convolver pulses and
// frame completions into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_linebuf_sched;
  localparam int BD  = 8;
  localparam int C   = 28;
  localparam int R   = 28;
  localparam int TMO = 16;

  typedef struct {
    logic [1:0]    slot;
    logic [31:0]   col;
    logic [BD-1:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  stride;
    logic [1:0]  top;
    logic [31:0] row;
    int          pix;
  } conv_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [1:0]    stride = 2'd0;
  logic          pix_valid = 1'b0;
  logic [BD-1:0] pix_data = '0;
  logic          resp_done = 1'b0;
  logic          spur_done = 1'b0;
  bit            src_en = 1'b0;
  bit            src_rand = 1'b0;
  bit            resp_en = 1'b1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int conv_total = 0;
  int conv_in_frame = 0;
  int pix_since = 0;

  wr_t   exp_wr[$];
  conv_t exp_conv[$];
  int    exp_done[$];

  always #5 clk = ~clk;

  linebuf_sched_if #(.BIT_DEPTH(BD), .COLS(C), .IMG_ROWS(R)) bus ();

  assign bus.frame_start = frame_start;
  assign bus.stride      = stride;
  assign bus.pix_valid   = pix_valid;
  assign bus.pix_data    = pix_data;
  assign bus.conv_done   = resp_done | spur_done;

  linebuf_sched #(
    .BIT_DEPTH(BD), .COLS(C), .IMG_ROWS(R), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BD-1:0] pat(input int k);
    return BD'((k * 37 + 11) % 251);
  endfunction

  // Expected traffic for one whole frame: every pixel write, every convolver pulse, one completion.
  task automatic push_frame(input bit s2);
    int s, passes, rows;
    s      = s2 ? 2 : 1;
    passes = (R - 3) / s + 1;
    rows   = 3 + (passes - 1) * s;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < C; c++) begin
        wr_t w;
        w.slot = 2'(r % 3);
        w.col  = 32'(c);
        w.data = pat(r * C + c);
        exp_wr.push_back(w);
      end
    end
    for (int p = 0; p < passes; p++) begin
      conv_t e;
      e.stride = 2'(s);
      e.top    = 2'((p * s) % 3);
      e.row    = 32'(p);
      e.pix    = (p == 0) ? 3 * C : s * C;
      exp_conv.push_back(e);
    end
    exp_done.push_back(passes);
  endtask

  task automatic flush();
    exp_wr.delete();
    exp_conv.delete();
    exp_done.delete();
  endtask

  task automatic start_frame(input logic [1:0] s);
    @(posedge clk); #1;
    flush();
    push_frame(s == 2'd2);
    stride      = s;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    stride      = 2'd0;
  endtask

  task automatic finish_frame(input int c0, input int d0, input int exp_passes, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_frame_done"}, 32'(done_cnt - d0), 1);
    repeat (4) @(negedge clk);
    check({tag, "_single_done"}, 32'(done_cnt - d0), 1);
    check({tag, "_conv_pulses"}, 32'(conv_total - c0), 32'(exp_passes));
    check({tag, "_busy_after"}, 32'(bus.busy), 0);
    check({tag, "_out_row_after"}, 32'(bus.out_row), 0);
    check({tag, "_pix_ready_after"}, 32'(bus.pix_ready), 0);
    check({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
    check({tag, "_conv_left"}, 32'(exp_conv.size()), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_ready"}, 32'(bus.pix_ready), 0);
    check({tag, "_lb_wr_en"}, 32'(bus.lb_wr_en), 0);
    check({tag, "_lb_row_sel"}, 32'(bus.lb_row_sel), 0);
    check({tag, "_lb_col"}, 32'(bus.lb_col), 0);
    check({tag, "_lb_data"}, 32'(bus.lb_data), 0);
    check({tag, "_conv_start"}, 32'(bus.conv_start), 0);
    check({tag, "_conv_stride"}, 32'(bus.conv_stride), 0);
    check({tag, "_conv_top_slot"}, 32'(bus.conv_top_slot), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    check({tag, "_out_row"}, 32'(bus.out_row), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
  endtask

  // Pixel source: pixel k of a frame carries pat(k); restarts its count on an accepted frame_start.
  initial begin
    int  idx;
    bit  xfer, restart;
    idx = 0;
    forever begin
      @(negedge clk);
      xfer    = pix_valid && bus.pix_ready && !rst;
      restart = frame_start && !bus.busy && !rst;
      @(posedge clk); #1;
      if (restart)   idx = 0;
      else if (xfer) idx++;
      pix_valid = src_en && (!src_rand || ($urandom_range(0, 1) == 1));
      pix_data  = pat(idx);
    end
  end

  // Convolver model: answers each conv_start with conv_done five cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.conv_start && resp_en && !rst) begin
        repeat (5) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    wr_t   w;
    conv_t e;
    int    n;
    forever begin
      @(negedge clk);
      if (rst) begin
        pix_since     = 0;
        conv_in_frame = 0;
      end else begin
        if (bus.lb_wr_en) begin
          pix_since++;
          check("wr_only_when_valid", 32'(pix_valid), 1);
          check("wr_expected", 32'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_row_sel", 32'(bus.lb_row_sel), 32'(w.slot));
            check("wr_col", 32'(bus.lb_col), w.col);
            check("wr_data", 32'(bus.lb_data), 32'(w.data));
          end
        end
        if (bus.conv_start) begin
          conv_total++;
          conv_in_frame++;
          check("conv_expected", 32'(exp_conv.size() != 0), 1);
          check("conv_done_overlap", 32'(bus.frame_done), 0);
          if (exp_conv.size() != 0) begin
            e = exp_conv.pop_front();
            check("conv_stride", 32'(bus.conv_stride), 32'(e.stride));
            check("conv_top_slot", 32'(bus.conv_top_slot), 32'(e.top));
            check("conv_out_row", 32'(bus.out_row), e.row);
            check("conv_pix_count", 32'(pix_since), 32'(e.pix));
          end
          pix_since = 0;
        end
        if (bus.frame_done) begin
          done_cnt++;
          check("done_expected", 32'(exp_done.size() != 0), 1);
          if (exp_done.size() != 0) begin
            n = exp_done.pop_front();
            check("passes_per_frame", 32'(conv_in_frame), 32'(n));
          end
          conv_in_frame = 0;
        end
        if (bus.err) err_cnt++;
      end
    end
  end

  initial begin
    int c0, d0, e0, n;

    // Reset held against frame_start and conv_done.
    src_en      = 1'b1;
    frame_start = 1'b1;
    spur_done   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    frame_start = 1'b0;
    spur_done   = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Stride 1, continuous pixels: 26 passes.
    c0 = conv_total; d0 = done_cnt;
    start_frame(2'd1);
    finish_frame(c0, d0, 26, "s1");

    // Stride 2, continuous pixels: 13 passes, top slot 0,2,1,0...
    c0 = conv_total; d0 = done_cnt;
    start_frame(2'd2);
    finish_frame(c0, d0, 13, "s2");

    // Stride code 3 behaves as stride 1; source valid toggles randomly.
    src_rand = 1'b1;
    c0 = conv_total; d0 = done_cnt;
    start_frame(2'd3);
    finish_frame(c0, d0, 26, "s3_rand");
    src_rand = 1'b0;

    // frame_start while busy and conv_done during FILL change nothing.
    c0 = conv_total; d0 = done_cnt;
    start_frame(2'd1);
    repeat (20) @(posedge clk);
    #1 spur_done = 1'b1;
    frame_start = 1'b1;
    stride      = 2'd2;
    @(posedge clk);
    #1 spur_done = 1'b0;
    frame_start = 1'b0;
    stride      = 2'd0;
    repeat (300) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    finish_frame(c0, d0, 26, "busy_ignore");

    // Reset in the REFILL that precedes pass 7, then a clean frame.
    c0 = conv_total; d0 = done_cnt;
    start_frame(2'd1);
    n = 0;
    while (!((conv_total - c0) == 7 && bus.pix_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_refill", 32'(conv_total - c0), 7);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    frame_start = 1'b1;
    spur_done   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    frame_start = 1'b0;
    spur_done   = 1'b0;
    flush();
    @(negedge clk);
    check_zero("midrst");
    check("midrst_no_done", 32'(done_cnt - d0), 0);
    c0 = conv_total; d0 = done_cnt;
    start_frame(2'd1);
    finish_frame(c0, d0, 26, "after_rst");

    // conv_done withheld after the first pulse.
    resp_en = 1'b0;
    c0 = conv_total; d0 = done_cnt; e0 = err_cnt;
    start_frame(2'd1);
    n = 0;
    while (conv_total == c0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("hold_conv_seen", 32'(conv_total - c0), 1);
    repeat (40) @(negedge clk);
`ifdef LINEBUF_SCHED_TIMEOUT_EN
    check("hold_err_pulses", 32'(err_cnt - e0), 1);
    check("hold_busy", 32'(bus.busy), 0);
`else
    check("hold_err_pulses", 32'(err_cnt - e0), 0);
    check("hold_busy", 32'(bus.busy), 1);
    check("hold_pix_ready", 32'(bus.pix_ready), 0);
`endif
    check("hold_no_done", 32'(done_cnt - d0), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    flush();
    resp_en = 1'b1;
    @(negedge clk);
    check_zero("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
